maze_solver_param: RTL and testbench

- Parametrised successor to the fixed 16x16 rat-in-maze solver.
- Depth-first search over an external maze memory of arbitrary power-of-two dimensions.
- Keeps an internal visited bitmap and a move stack; reports pass/fail and the path length; replays the solved path one move per cycle on request.
- Sits between the game top level and the maze memory: it drives the memory read port and presents the move stream to the game.

---
 rtl/maze_solver_param.sv | 233 +++++++++++++++++++++++
 tb/tb_maze_solver_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_solver_param.sv
// Depth-first rat-in-maze solver over an external 1-bit maze memory of
// 2^X_W x 2^Y_W cells; stores the winning moves and replays them on request.
module maze_solver_param #(
  parameter int X_W = 4,
  parameter int Y_W = 4,
  parameter int STACK_DEPTH = 255,
  localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            run,
  output logic [X_W-1:0]  mem_x,
  output logic [Y_W-1:0]  mem_y,
  output logic            mem_rd,
  input  logic            mem_dout,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [1:0]      move,
  output logic            move_valid,
  output logic [SP_W-1:0] path_len
);

  localparam int CELLS = 1 << (X_W + Y_W);
  localparam int STACK_SLOTS = 1 << SP_W;
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {IDLE, INIT, CHECK, EVAL, BACK, DONE, REPLAY, FAIL} state_e;

  state_e            state_q, state_d;
  logic              init_wait_q, init_wait_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [1:0]        dir_q, dir_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [SP_W-1:0]   idx_q, idx_d;
  logic [CELLS-1:0]  visited_q, visited_d;
  logic [1:0]        stack_q [STACK_SLOTS];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [1:0]        move_q, move_d;
  logic              move_valid_q, move_valid_d;
  logic [SP_W-1:0]   path_len_q, path_len_d;

  logic              push_en;
  logic [1:0]        top_dir;
  logic [1:0]        rep_dir;
  logic [X_W-1:0]    cand_x, back_x;
  logic [Y_W-1:0]    cand_y, back_y;
  logic              cand_oob, cand_seen, cand_goal;

  assign top_dir = stack_q[sp_q - 1'b1];
  assign rep_dir = stack_q[idx_q];

  // Neighbour in the current direction; the step wraps, so cand_oob masks it.
  always_comb begin
    cand_x   = x_q;
    cand_y   = y_q;
    cand_oob = 1'b0;
    case (dir_q)
      2'd0:    begin cand_x = x_q + 1'b1; cand_oob = (x_q == X_MAX); end
      2'd1:    begin cand_y = y_q + 1'b1; cand_oob = (y_q == Y_MAX); end
      2'd2:    begin cand_x = x_q - 1'b1; cand_oob = (x_q == '0);    end
      default: begin cand_y = y_q - 1'b1; cand_oob = (y_q == '0);    end
    endcase
    cand_seen = visited_q[{cand_y, cand_x}];
    cand_goal = (cand_x == X_MAX) && (cand_y == Y_MAX);
  end

  always_comb begin
    back_x = x_q;
    back_y = y_q;
    case (top_dir)
      2'd0:    back_x = x_q - 1'b1;
      2'd1:    back_y = y_q - 1'b1;
      2'd2:    back_x = x_q + 1'b1;
      default: back_y = y_q + 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    init_wait_d  = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    sp_d         = sp_q;
    idx_d        = idx_q;
    visited_d    = visited_q;
    move_d       = move_q;
    move_valid_d = 1'b0;
    push_en      = 1'b0;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_d   = INIT;
          x_d       = '0;
          y_d       = '0;
          dir_d     = 2'd0;
          sp_d      = '0;
          idx_d     = '0;
          visited_d = '0;
        end else if (state_q == DONE && run && sp_q != '0) begin
          state_d      = REPLAY;
          move_d       = rep_dir;
          move_valid_d = 1'b1;
          idx_d        = idx_q + 1'b1;
        end
      end
      // First INIT cycle issues the read of (0,0); the second sees its data.
      INIT: begin
        if (!init_wait_q) begin
          init_wait_d = 1'b1;
        end else if (mem_dout) begin
          state_d = FAIL;
        end else begin
          visited_d[0] = 1'b1;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (cand_oob || cand_seen) begin
          if (dir_q == 2'd3) state_d = BACK;
          else               dir_d = dir_q + 1'b1;
        end else begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (mem_dout) begin
          if (dir_q == 2'd3) state_d = BACK;
          else begin
            dir_d   = dir_q + 1'b1;
            state_d = CHECK;
          end
        end else if (sp_q == SP_FULL) begin
          state_d = FAIL;
        end else begin
          push_en                    = 1'b1;
          sp_d                       = sp_q + 1'b1;
          visited_d[{cand_y, cand_x}] = 1'b1;
          x_d                        = cand_x;
          y_d                        = cand_y;
          dir_d                      = 2'd0;
          state_d                    = cand_goal ? DONE : CHECK;
        end
      end
      BACK: begin
        if (sp_q == '0) begin
          state_d = FAIL;
        end else begin
          sp_d = sp_q - 1'b1;
          x_d  = back_x;
          y_d  = back_y;
          if (top_dir != 2'd3) begin
            dir_d   = top_dir + 1'b1;
            state_d = CHECK;
          end
        end
      end
      REPLAY: begin
        if (idx_q == sp_q) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          move_d       = rep_dir;
          move_valid_d = 1'b1;
          idx_d        = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = state_d inside {INIT, CHECK, EVAL, BACK, REPLAY};
    done_d     = state_d inside {DONE, REPLAY};
    fail_d     = (state_d == FAIL);
    path_len_d = done_d ? sp_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      init_wait_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      dir_q        <= 2'd0;
      sp_q         <= '0;
      idx_q        <= '0;
      visited_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      move_q       <= 2'd0;
      move_valid_q <= 1'b0;
      path_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_wait_q  <= init_wait_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      sp_q         <= sp_d;
      idx_q        <= idx_d;
      visited_q    <= visited_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      move_q       <= move_d;
      move_valid_q <= move_valid_d;
      path_len_q   <= path_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q] <= dir_q;
  end

  // The read port follows the state directly so data returns in EVAL.
  assign mem_rd     = (state_q == INIT && !init_wait_q) ||
                      (state_q == CHECK && !cand_oob && !cand_seen);
  assign mem_x      = (state_q == CHECK) ? cand_x : '0;
  assign mem_y      = (state_q == CHECK) ? cand_y : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign move       = move_q;
  assign move_valid = move_valid_q;
  assign path_len   = path_len_q;

endmodule

// File: tb/tb_maze_solver_param.sv
// Randomised self-checking bench for maze_solver_param: a queue-based DFS model
// predicts outcome and path, and a per-cycle monitor checks the DUT against it.
`timescale 1ns/1ps
module tb_maze_solver_param;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DEPTH = 255;
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int NX = 1 << XW;
  localparam int NY = 1 << YW;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic run = 1'b0;
  logic [XW-1:0] mem_x;
  logic [YW-1:0] mem_y;
  logic mem_rd;
  logic mem_dout = 1'b0;
  logic busy, done, fail, move_valid;
  logic [1:0] move;
  logic [SPW-1:0] path_len;

  logic start2 = 1'b0;
  logic run2 = 1'b0;
  logic mem_dout2 = 1'b0;
  logic [2:0] mem_x2;
  logic [1:0] mem_y2;
  logic mem_rd2, busy2, done2, fail2, move_valid2;
  logic [1:0] move2;
  logic [2:0] path_len2;

  bit maze [NY][NX];
  bit readSeen [NY][NX];
  int expPath [$];
  bit expOk;
  int expLen;
  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;
  int replayIdx = 0;
  int prevMove = -1;

  maze_solver_param #(.X_W(XW), .Y_W(YW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .run(run),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd), .mem_dout(mem_dout),
    .busy(busy), .done(done), .fail(fail), .move(move),
    .move_valid(move_valid), .path_len(path_len)
  );

  // Small open maze whose stack is too shallow for any path to the goal.
  maze_solver_param #(.X_W(3), .Y_W(2), .STACK_DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .run(run2),
    .mem_x(mem_x2), .mem_y(mem_y2), .mem_rd(mem_rd2), .mem_dout(mem_dout2),
    .busy(busy2), .done(done2), .fail(fail2), .move(move2),
    .move_valid(move_valid2), .path_len(path_len2)
  );

  always #5 clk = ~clk;

  // Synchronous maze memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_dout <= maze[mem_y][mem_x];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void clearMaze();
    foreach (maze[i, j]) maze[i][j] = 1'b0;
  endfunction

  // Plain DFS: try right, down, left, up in order; pop and resume after the
  // popped direction when a cell is exhausted.
  function automatic void solveModel();
    bit seen [NY][NX];
    int st [$];
    int dx [4] = '{1, 0, -1, 0};
    int dy [4] = '{0, 1, 0, -1};
    int px, py, d, nx, ny, e;
    foreach (seen[i, j]) seen[i][j] = 1'b0;
    expPath.delete();
    expOk = 1'b0;
    expLen = 0;
    px = 0; py = 0; d = 0;
    if (maze[0][0]) return;
    seen[0][0] = 1'b1;
    for (int guard = 0; guard < 100000; guard++) begin
      if (d < 4) begin
        nx = px + dx[d];
        ny = py + dy[d];
        if (nx >= 0 && nx < NX && ny >= 0 && ny < NY && !seen[ny][nx] && !maze[ny][nx]) begin
          if (st.size() == DEPTH) return;
          st.push_back(d);
          seen[ny][nx] = 1'b1;
          px = nx; py = ny; d = 0;
          if (px == NX - 1 && py == NY - 1) begin
            expOk = 1'b1;
            expPath = st;
            expLen = st.size();
            return;
          end
        end else begin
          d++;
        end
      end else begin
        if (st.size() == 0) return;
        e = st.pop_back();
        px -= dx[e];
        py -= dy[e];
        d = e + 1;
      end
    end
  endfunction

  // Per-cycle monitor comparing the DUT against the model's expectations.
  initial begin : compareProc
    forever begin
      @(negedge clk);
      if (!rst) begin
        replayIdx = 0;
        prevMove = -1;
      end else if (checkEn) begin
        if (done || fail)
          checkOutput("outcome", {done, fail}, expOk ? 2'b10 : 2'b01);
        if (fail) checkOutput("fail_path_len", path_len, 0);
        if (done && !move_valid) checkOutput("done_path_len", path_len, expLen);
        if (move_valid) begin
          checkOutput("replay_busy_done", {busy, done}, 2'b11);
          if (replayIdx < expLen) checkOutput("replay_move", move, expPath[replayIdx]);
          else checkOutput("replay_overrun", replayIdx, expLen);
          if (prevMove >= 0) checkOutput("no_back_forth", (move == (prevMove ^ 2)), 0);
          prevMove = move;
          replayIdx++;
        end
        if (mem_rd) begin
          checkOutput("rd_while_busy", busy, 1);
          if (!maze[mem_y][mem_x]) begin
            checkOutput("reread_open_cell", readSeen[mem_y][mem_x], 0);
            readSeen[mem_y][mem_x] = 1'b1;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit doStart, input bit doRun);
    @(negedge clk);
    start = doStart;
    run = doRun;
    @(negedge clk);
    start = 1'b0;
    run = 1'b0;
  endtask

  task automatic launchSearch(output int cycles);
    @(negedge clk);
    checkEn = 1'b0;
    solveModel();
    foreach (readSeen[i, j]) readSeen[i][j] = 1'b0;
    replayIdx = 0;
    prevMove = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkEn = 1'b1;
    cycles = 0;
    while (!(done || fail) && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("search_terminates", done | fail, 1);
  endtask

  task automatic replayPath(output int count);
    replayIdx = 0;
    prevMove = -1;
    applyStimulus(1'b0, 1'b1);
    count = 0;
    while (move_valid && count < 1000) begin
      count++;
      @(negedge clk);
    end
    checkOutput("replay_count", count, expLen);
    checkOutput("after_replay", {busy, done, move_valid}, 3'b010);
  endtask

  initial begin : watchdog
    #3ms;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int cycles, count, rds, b;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {busy, done, fail, move_valid, mem_rd, move, path_len, mem_x, mem_y}, 0);
    checkOutput("reset_small", {busy2, done2, fail2, move_valid2, mem_rd2, move2, path_len2}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Open maze: straight right along row 0, then down column 15.
    clearMaze();
    launchSearch(cycles);
    checkOutput("open_done", {done, fail}, 2'b10);
    checkOutput("open_len", path_len, 30);
    checkOutput("open_model_len", expLen, 30);
    for (int k = 0; k < expLen; k++) checkOutput("open_model_path", expPath[k], (k < 15) ? 0 : 1);
    replayPath(count);
    checkOutput("open_replay_count", count, 30);

    // Wall on the start cell.
    clearMaze();
    maze[0][0] = 1'b1;
    launchSearch(cycles);
    checkOutput("wall_fail_latency", cycles, 2);
    checkOutput("wall_fail", {done, fail, path_len}, {2'b01, 8'd0});
    rds = 0;
    repeat (10) begin
      @(negedge clk);
      rds += int'(mem_rd);
    end
    checkOutput("wall_no_reads", rds, 0);

    // Goal sealed off: exhaustive search must end in fail.
    clearMaze();
    maze[15][14] = 1'b1;
    maze[14][15] = 1'b1;
    launchSearch(cycles);
    checkOutput("enclosed_fail", {done, fail}, 2'b01);
    checkOutput("enclosed_len", path_len, 0);

    // Dead-end corridor (1..3,0) forces a three-cell backtrack.
    clearMaze();
    maze[0][4] = 1'b1;
    maze[1][1] = 1'b1;
    maze[1][2] = 1'b1;
    maze[1][3] = 1'b1;
    launchSearch(cycles);
    checkOutput("deadend_done", {done, fail}, 2'b10);
    checkOutput("deadend_len", path_len, 30);
    checkOutput("deadend_model_head", {expPath[0][1:0], expPath[1][1:0], expPath[2][1:0]}, 6'b010100);
    replayPath(count);

    // Random mazes with start and goal kept open.
    for (int r = 0; r < 8; r++) begin
      foreach (maze[i, j]) maze[i][j] = ($urandom_range(0, 99) < 28);
      maze[0][0] = 1'b0;
      maze[NY-1][NX-1] = 1'b0;
      launchSearch(cycles);
      checkOutput("rand_outcome", {done, fail}, expOk ? 2'b10 : 2'b01);
      if (done) replayPath(count);
    end

    // Reset in the middle of a replay, then a fresh solve.
    clearMaze();
    launchSearch(cycles);
    replayIdx = 0;
    prevMove = -1;
    applyStimulus(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_midreplay",
                {busy, done, fail, move_valid, mem_rd, move, path_len, mem_x, mem_y}, 0);
    @(negedge clk);
    rst = 1'b1;
    launchSearch(cycles);
    checkOutput("post_reset_len", path_len, 30);

    // Stack overflow on the small instance: fifth push must fail.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    rds = 0;
    b = 0;
    while (!fail2 && b < BUDGET) begin
      if (mem_rd2) rds++;
      @(negedge clk);
      b++;
    end
    checkOutput("overflow_fail", {done2, fail2, path_len2}, 5'b01000);
    checkOutput("overflow_reads", rds, 6);
    checkOutput("overflow_idle", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
